product_accumulator: RTL and testbench
======================================

# product_accumulator

Sequential consumer for the 4x4 array multiplier's 8-bit product. It accepts a burst of N_TERMS products over a valid/ready handshake and sums them into a wide accumulator, forming a dot-product term. It presents the finished sum on a second valid/ready handshake. It sits directly downstream of the multiplier output `z`, which drives `p_data`.

## Interface
- `N_TERMS`, default 4: products summed per result; must be ≥1.
- `ACC_W`, default 12: accumulator/result width; must be ≥8.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a new sum; honoured only in IDLE.
- `p_valid` in 1: `p_data` valid.
- `p_ready` out 1: block accepts a product this cycle.
- `p_data` in 8: unsigned product from the multiplier.
- `sum_valid` out 1: `sum_data` holds a finished result.
- `sum_ready` in 1: downstream takes the result.
- `sum_data` out ACC_W: unsigned accumulated sum.
- `busy` out 1: state is not IDLE.
- `ovf` out 1: sticky overflow flag for the current or last sum.

## Operation
- FSM states:
  - IDLE: `p_ready`=0, `sum_valid`=0. On `start`, clear acc, cnt and `ovf`, then go to ACC.
  - ACC: `p_ready`=1. A product is accepted when `p_valid`&`p_ready`; then acc += `p_data` (zero-extended) and cnt += 1. Accepting with cnt==N_TERMS-1 goes to DONE.
  - DONE: `sum_valid`=1 and `sum_data`=acc, held stable. On `sum_ready`, go to IDLE.
- `start` outside IDLE is ignored and has no side effects.
- Cycles with `p_valid` low (bubbles) change nothing.
- `p_data` is sampled only on an accepting cycle.
- Overflow is detected from the carry-out of the ACC_W-bit add. On overflow, `ovf` is set and stays set until the next accepted `start` or reset.
- Accumulator behaviour on overflow is set by the macro in Configuration.
- `busy` = (state != IDLE).
- `sum_data` reads 0 outside DONE.

## Timing
- Reset (`rst_n` low at a clock edge): state IDLE, acc=0, cnt=0. All outputs 0: `p_ready`, `sum_valid`, `sum_data`, `busy`, `ovf`.
- Reset mid-operation discards the partial sum; no result is emitted.
- `start` sampled in IDLE at edge k gives `p_ready`=1 from cycle k+1.
- The last product accepted at edge k gives `sum_valid`=1 in cycle k+1. There is no combinational path from `p_data` to `sum_data`.
- The result handshake completes at the edge where `sum_valid`&`sum_ready`. The state is IDLE the next cycle, and a new `start` is accepted no earlier than that cycle.
- Minimum period per result: 1 (start) + N_TERMS + 1 (DONE) cycles.
- `p_ready` and `sum_valid` are decoded from registered state only; neither depends combinationally on `p_valid` or `sum_ready`.

## Configuration
- Macro: `PRODUCT_ACCUMULATOR_SATURATE_EN`.
- Defined: on overflow, acc clamps to all-ones (2^ACC_W-1) and stays clamped for the rest of the sum; `ovf` is set.
- Undefined: acc wraps modulo 2^ACC_W; `ovf` is set.

## Structure
- Shared package `product_accumulator_pkg` holds:
  - the state typedef {IDLE, ACC, DONE};
  - constant PROD_W=8;
  - helper function for the minimum overflow-free width, 8+clog2(N_TERMS).
- One sub-module: `acc_adder`, a combinational ACC_W-bit unsigned adder with carry-out feeding the overflow logic.
- Counter width is clog2(N_TERMS), minimum 1.

## Test plan
- Basic sum (N_TERMS=4, ACC_W=12): start, then products 3,5,7,9 back-to-back. Expect `sum_valid` one cycle after the 4th accept, `sum_data`=24, `ovf`=0.
- Max products (N_TERMS=4, ACC_W=12): four products of 225. Expect `sum_data`=900, `ovf`=0.
- Bubbles: products 1,2,3,4 with `p_valid` low for 2 cycles between each. Expect `sum_data`=10, and `sum_valid` exactly one cycle after the 4th accept.
- Backpressure: hold `sum_ready`=0 for 5 cycles and pulse `start` during DONE. Expect `sum_data` and `sum_valid` stable, `p_ready`=0, start ignored, IDLE after `sum_ready`.
- Overflow (N_TERMS=4, ACC_W=9): four products of 225. Without the macro expect `sum_data`=388 and `ovf`=1. With `PRODUCT_ACCUMULATOR_SATURATE_EN` expect `sum_data`=511 and `ovf`=1. A following start clears `ovf`.
- Reset mid-sum: `rst_n` low after 2 of 4 products. Expect all outputs 0 and IDLE the next cycle. A new start with 1,1,1,1 then yields 4.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
// Optional build macro: PRODUCT_ACCUMULATOR_SATURATE_EN (see product_accumulator.sv).
package product_accumulator_pkg;

   // Controller states: waiting for start, collecting products, holding result
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Width of one product coming from the 4x4 multiplier
   localparam int PROD_W = 8;

   // Smallest accumulator width that can never overflow for n_terms products
   function automatic int min_acc_w(input int n_terms);
      return PROD_W + $clog2(n_terms);
   endfunction

endpackage

// File: rtl/acc_adder.sv
// Combinational W-bit unsigned adder with carry-out; the carry drives the
// accumulator's overflow detection.
module acc_adder #(
   parameter int W = 12
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o,
   output logic         carry_o
);

   // One extra bit on the add exposes the carry-out
   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/product_accumulator.sv
// Sums a burst of N_TERMS 8-bit products into an ACC_W-bit accumulator and
// presents the result on a valid/ready output handshake.
// Build macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined the accumulator
// clamps to all-ones on overflow; otherwise it wraps modulo 2^ACC_W.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid driven here come from registered state only, and
// the sender's data must be stable while its valid is high.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             p_valid,
   output logic             p_ready,
   input  logic [7:0]       p_data,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [ACC_W-1:0] sum_data,
   output logic             busy,
   output logic             ovf
);

   localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
   // When the width covers the worst-case sum the carry can never fire
   localparam bit CAN_OVF = (ACC_W < min_acc_w(N_TERMS));

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [ACC_W-1:0] p_ext;
   logic [ACC_W-1:0] add_sum;
   logic             add_carry;
   logic [ACC_W-1:0] acc_next;
   logic             accept;

   assign p_ext  = ACC_W'(p_data);
   assign accept = p_valid && (state_q == ACC);

   acc_adder #(.W(ACC_W)) u_adder (
      .a_i     (acc_q),
      .b_i     (p_ext),
      .sum_o   (add_sum),
      .carry_o (add_carry)
   );

   // Overflow policy for the value written back into the accumulator
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   assign acc_next = add_carry ? {ACC_W{1'b1}} : add_sum;
`else
   assign acc_next = add_sum;
`endif

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state and datapath update; everything holds unless an event occurs
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_d = acc_next;
               cnt_d = cnt_q + 1'b1;
               if (CAN_OVF && add_carry) ovf_d = 1'b1;
               if (cnt_q == LAST_CNT) state_d = DONE;
            end
         end
         DONE: begin
            if (sum_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign p_ready   = (state_q == ACC);
   assign sum_valid = (state_q == DONE);
   assign sum_data  = sum_valid ? acc_q : '0;
   assign busy      = (state_q != IDLE);
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: one instance at ACC_W=12 and one at
// ACC_W=9 (overflow cases), each checked every cycle against a sum model.
module tb_product_accumulator;

   localparam int N  = 4;
   localparam int W0 = 12;
   localparam int W1 = 9;

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      start = '0, p_valid = '0, sum_ready = '0;
   logic [1:0][7:0] p_data = '0;
   logic [1:0]      p_ready, sum_valid, busy, ovf;
   logic [W0-1:0]   sd0;
   logic [W1-1:0]   sd1;

   product_accumulator #(.N_TERMS(N), .ACC_W(W0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .p_valid(p_valid[0]),
      .p_ready(p_ready[0]), .p_data(p_data[0]), .sum_valid(sum_valid[0]),
      .sum_ready(sum_ready[0]), .sum_data(sd0), .busy(busy[0]), .ovf(ovf[0])
   );

   product_accumulator #(.N_TERMS(N), .ACC_W(W1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .p_valid(p_valid[1]),
      .p_ready(p_ready[1]), .p_data(p_data[1]), .sum_valid(sum_valid[1]),
      .sum_ready(sum_ready[1]), .sum_data(sd1), .busy(busy[1]), .ovf(ovf[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sd_of(input int i);
      return (i == 0) ? int'(sd0) : int'(sd1);
   endfunction

   // ---------------- behavioural model ----------------
   // mode: 0 waiting, 1 collecting, 2 result held. total is the exact
   // (unbounded) sum of accepted products since the last accepted start.
   int m_mode[2], m_total[2], m_cnt[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_mode[i] = 0; m_total[i] = 0; m_cnt[i] = 0;
         end else if (m_mode[i] == 0) begin
            if (start[i]) begin
               m_total[i] = 0; m_cnt[i] = 0; m_mode[i] = 1;
            end
         end else if (m_mode[i] == 1) begin
            if (p_valid[i]) begin
               m_total[i] += int'(p_data[i]);
               m_cnt[i]++;
               if (m_cnt[i] == N) m_mode[i] = 2;
            end
         end else begin
            if (sum_ready[i]) m_mode[i] = 0;
         end
      end
   end

   function automatic int lim_of(input int i);
      return 1 << ((i == 0) ? W0 : W1);
   endfunction

   function automatic int exp_sum(input int i);
      if (m_mode[i] != 2) return 0;
      if (m_total[i] < lim_of(i)) return m_total[i];
      return SAT ? lim_of(i) - 1 : m_total[i] % lim_of(i);
   endfunction

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("p_ready%0d", i), int'(p_ready[i]), int'(m_mode[i] == 1));
            chk($sformatf("sum_valid%0d", i), int'(sum_valid[i]), int'(m_mode[i] == 2));
            chk($sformatf("busy%0d", i), int'(busy[i]), int'(m_mode[i] != 0));
            chk($sformatf("ovf%0d", i), int'(ovf[i]), int'(m_total[i] >= lim_of(i)));
            chk($sformatf("sum_data%0d", i), sd_of(i), exp_sum(i));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_start(input int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic send(input int i, input int d, input int gap);
      bit acc_ok;
      int budget;
      p_valid[i] = 1'b1;
      p_data[i]  = 8'(d);
      acc_ok = 1'b0;
      budget = 0;
      while (!acc_ok && budget < 50) begin
         acc_ok = p_ready[i];
         tick();
         budget++;
      end
      if (!acc_ok) chk($sformatf("accept_timeout%0d", i), 0, 1);
      p_valid[i] = 1'b0;
      p_data[i]  = 8'hA5;  // garbage between accepts must not matter
      repeat (gap) tick();
   endtask

   // Expect the result right after the last accept, hold it, then take it.
   task automatic take_sum(input int i, input int exp, input int exp_ovf,
                           input int hold, input bit poke_start);
      int waited = 0;
      while (!sum_valid[i] && waited < 50) begin
         tick();
         waited++;
      end
      chk($sformatf("latency%0d", i), waited, 0);
      chk($sformatf("sum_lit%0d", i), sd_of(i), exp);
      chk($sformatf("ovf_lit%0d", i), int'(ovf[i]), exp_ovf);
      for (int j = 0; j < hold; j++) begin
         if (poke_start && j == 2) start[i] = 1'b1;
         tick();
         start[i] = 1'b0;
         chk($sformatf("hold_sum%0d", i), sd_of(i), exp);
         chk($sformatf("hold_pready%0d", i), int'(p_ready[i]), 0);
      end
      sum_ready[i] = 1'b1;
      tick();
      sum_ready[i] = 1'b0;
      chk($sformatf("idle_after%0d", i), int'(busy[i]), 0);
      tick();
      chk($sformatf("still_idle%0d", i), int'(busy[i]), 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      p_data[0] = '0;
      p_data[1] = '0;
      @(posedge clk);
      chk_en = 1'b1;
      tick();
      // reset state
      chk("rst_busy", int'(busy[0]), 0);
      chk("rst_sum", sd_of(0), 0);
      rst_n = 1'b1;
      tick();

      // basic sum 3+5+7+9 with backpressure and a start during DONE
      do_start(0);
      send(0, 3, 0); send(0, 5, 0); send(0, 7, 0); send(0, 9, 0);
      take_sum(0, 24, 0, 5, 1'b1);

      // max products: 4 x 225 = 900
      do_start(0);
      for (int k = 0; k < 4; k++) send(0, 225, 0);
      take_sum(0, 900, 0, 0, 1'b0);

      // bubbles of two cycles between products
      do_start(0);
      send(0, 1, 2); send(0, 2, 2); send(0, 3, 2); send(0, 4, 0);
      take_sum(0, 10, 0, 1, 1'b0);

      // overflow at ACC_W=9: 900 wraps to 388, or clamps to 511
      do_start(1);
      for (int k = 0; k < 4; k++) send(1, 225, 0);
      take_sum(1, SAT ? 511 : 388, 1, 2, 1'b0);
      chk("ovf_sticky_idle", int'(ovf[1]), 1);
      do_start(1);
      chk("ovf_cleared", int'(ovf[1]), 0);
      send(1, 100, 0); send(1, 200, 0); send(1, 0, 0); send(1, 211, 0);
      take_sum(1, 511, 0, 0, 1'b0);

      // reset mid-sum, then a clean 1+1+1+1
      do_start(0);
      send(0, 50, 0); send(0, 60, 0);
      rst_n = 1'b0;
      tick();
      chk("midrst_busy", int'(busy[0]), 0);
      chk("midrst_pready", int'(p_ready[0]), 0);
      chk("midrst_valid", int'(sum_valid[0]), 0);
      rst_n = 1'b1;
      tick();
      do_start(0);
      for (int k = 0; k < 4; k++) send(0, 1, 0);
      take_sum(0, 4, 0, 0, 1'b0);

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
